// File: rtl/cpu_ctrl_sequencer_if.sv
// Bundle of signals between the fetch/decode/execute sequencer and its
// surroundings: instruction memory, register file, ALU and the run/status lines.
interface cpu_ctrl_sequencer_if #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
);
  logic             run;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_ack;
  logic [7:0]       imem_rdata;
  logic [1:0]       rf_ra;
  logic [1:0]       rf_rb;
  logic [7:0]       rf_rb_data;
  logic [2:0]       alu_opcode;
  logic             is_zero;
  logic             rf_we;
  logic             halted;
  logic [CNT_W-1:0] retired;

  // Sequencer side
  modport master (
    input  run, imem_ack, imem_rdata, rf_rb_data, is_zero,
    output imem_req, imem_addr, rf_ra, rf_rb, alu_opcode, rf_we, halted, retired
  );

  // Environment side (memory, register file, ALU, host)
  modport slave (
    output run, imem_ack, imem_rdata, rf_rb_data, is_zero,
    input  imem_req, imem_addr, rf_ra, rf_rb, alu_opcode, rf_we, halted, retired
  );
endinterface

// File: rtl/cpu_ctrl_sequencer.sv
// Multi-cycle fetch/decode/execute controller in front of the 8-bit ALU.
// IDLE -> FETCH (req/ack) -> DECODE -> EXEC -> FETCH ... until HALT retires.
// All outputs are decoded from registered state, so an asynchronous reset
// drops imem_req/rf_we in the same cycle it is asserted.
module cpu_ctrl_sequencer #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input logic                 clk,
  input logic                 rst,
  cpu_ctrl_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [2:0] OP_NOP0 = 3'b000;
  localparam logic [2:0] OP_JZ   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_MOV  = 3'b101;
  localparam logic [2:0] OP_NOP1 = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [7:0]       ir_q, ir_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic             imem_req_o;
  logic             rf_we_o;
  logic             halted_o;
  logic [2:0]       alu_opcode_o;
  logic [1:0]       rf_ra_o;
  logic [1:0]       rf_rb_o;

  // Instruction fields; bit 0 of the instruction word carries no meaning.
  logic [2:0] ir_op;
  logic [1:0] ir_ra;
  logic [1:0] ir_rb;
  logic       unused_ir_bit;

  assign ir_op         = ir_q[7:5];
  assign ir_ra         = ir_q[4:3];
  assign ir_rb         = ir_q[2:1];
  assign unused_ir_bit = ir_q[0];

  // State, program counter, instruction register and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  // Next-state logic and control outputs for the sequencer FSM.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    retired_d    = retired_q;
    imem_req_o   = 1'b0;
    rf_we_o      = 1'b0;
    halted_o     = 1'b0;
    alu_opcode_o = 3'b000;
    rf_ra_o      = 2'b00;
    rf_rb_o      = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        // Request is held (address = pc) until the memory acknowledges;
        // ack in the same cycle as the first request is allowed.
        imem_req_o = 1'b1;
        if (bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        alu_opcode_o = ir_op;
        rf_ra_o      = ir_ra;
        rf_rb_o      = ir_rb;
        state_d      = S_EXEC;
      end

      S_EXEC: begin
        // Decode outputs stay valid so the ALU result/flag is stable here.
        alu_opcode_o = ir_op;
        rf_ra_o      = ir_ra;
        rf_rb_o      = ir_rb;
        retired_d    = retired_q + 1'b1;
        state_d      = S_FETCH;
        case (ir_op)
          OP_ADD, OP_AND, OP_XOR, OP_MOV: rf_we_o = 1'b1;
          OP_JZ: begin
            if (bus.is_zero) begin
              pc_d = bus.rf_rb_data[PC_W-1:0];
            end
          end
          OP_HALT: state_d = S_HALT;
          OP_NOP0, OP_NOP1: ;
          default: ;
        endcase
      end

      S_HALT: begin
        // Terminal until reset; run is not looked at here.
        halted_o = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.imem_req   = imem_req_o;
  assign bus.imem_addr  = pc_q;
  assign bus.rf_we      = rf_we_o;
  assign bus.halted     = halted_o;
  assign bus.alu_opcode = alu_opcode_o;
  assign bus.rf_ra      = rf_ra_o;
  assign bus.rf_rb      = rf_rb_o;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_cpu_ctrl_sequencer.sv
// Bench for cpu_ctrl_sequencer: behavioural instruction memory with per-address
// ack delay, per-instruction is_zero / jump-target tables, a scoreboard of
// expected fetches and writebacks, and directed cycle checks.
module tb_cpu_ctrl_sequencer;
  localparam int PC_W  = 8;
  localparam int CNT_W = 16;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] ret;
  } fexp_t;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  logic [7:0] imem [256];
  int         dly  [256];
  logic       zf   [256];
  logic [7:0] tgt  [256];
  logic [7:0] last_addr;

  fexp_t      fq [$];
  logic [6:0] wq [$];

  cpu_ctrl_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  cpu_ctrl_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file / ALU stand-in: flag and jump target of the instruction in flight.
  assign bus.is_zero    = zf[last_addr];
  assign bus.rf_rb_data = tgt[last_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Instruction memory responder: acks after dly[addr] cycles of request.
  initial begin
    int wcnt;
    wcnt = 0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!bus.imem_req) begin
        bus.imem_ack = 1'b0;
        wcnt = 0;
      end else if (wcnt >= dly[bus.imem_addr]) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = imem[bus.imem_addr];
        last_addr      = bus.imem_addr;
        wcnt = 0;
      end else begin
        bus.imem_ack = 1'b0;
        wcnt++;
      end
    end
  end

  // Monitor: pops and compares on every fetch handshake and every writeback.
  initial begin
    fexp_t e;
    logic [6:0] w;
    forever begin
      @(negedge clk);
      if (!rst && bus.imem_req && bus.imem_ack) begin
        $display("fetch addr=%02h retired=%0d", bus.imem_addr, bus.retired);
        if (fq.size() == 0) begin
          chk("fetch_unexpected", {24'd0, bus.imem_addr}, 32'hFFFF_FFFF);
        end else begin
          e = fq.pop_front();
          chk("fetch_addr", {24'd0, bus.imem_addr}, {24'd0, e.addr});
          chk("fetch_retired", {16'd0, bus.retired}, {16'd0, e.ret});
        end
      end
      if (!rst && bus.rf_we) begin
        $display("writeback ra=%0d rb=%0d op=%0d", bus.rf_ra, bus.rf_rb, bus.alu_opcode);
        if (wq.size() == 0) begin
          chk("wb_unexpected", {25'd0, bus.rf_ra, bus.rf_rb, bus.alu_opcode}, 32'hFFFF_FFFF);
        end else begin
          w = wq.pop_front();
          chk("wb_fields", {25'd0, bus.rf_ra, bus.rf_rb, bus.alu_opcode}, {25'd0, w});
        end
      end
    end
  end

  task automatic wait_halt(input int budget);
    int n;
    n = 0;
    while (!bus.halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("halt_reached", {31'd0, bus.halted}, 32'd1);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    int n_req;
    int bad;
    int n;
    for (int i = 0; i < 256; i++) begin
      imem[i] = 8'h00;
      dly[i]  = 0;
      zf[i]   = 1'b0;
      tgt[i]  = 8'h00;
    end
    last_addr = 8'h00;
    bus.run   = 1'b0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_we", {31'd0, bus.rf_we}, 32'd0);
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);
    chk("rst_retired", {16'd0, bus.retired}, 32'd0);
    chk("rst_addr", {24'd0, bus.imem_addr}, 32'd0);
    chk("rst_opcode", {29'd0, bus.alu_opcode}, 32'd0);

    // ADD ra=0 rb=2 with same-cycle ack, then HALT
    imem[0] = 8'h44;
    imem[1] = 8'hE0;
    fq.push_back('{addr: 8'h00, ret: 16'd0});
    fq.push_back('{addr: 8'h01, ret: 16'd1});
    wq.push_back({2'd0, 2'd2, 3'd2});
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_req", {31'd0, bus.imem_req}, 32'd0);
    bus.run = 1'b1;
    @(negedge clk);  // c1: FETCH
    bus.run = 1'b0;  // dropping run must not stop the program
    chk("c1_req", {31'd0, bus.imem_req}, 32'd1);
    chk("c1_opcode", {29'd0, bus.alu_opcode}, 32'd0);
    @(negedge clk);  // c2: DECODE
    chk("c2_opcode", {29'd0, bus.alu_opcode}, 32'd2);
    chk("c2_ra_rb", {28'd0, bus.rf_ra, bus.rf_rb}, 32'h2);
    chk("c2_we", {31'd0, bus.rf_we}, 32'd0);
    chk("c2_req", {31'd0, bus.imem_req}, 32'd0);
    @(negedge clk);  // c3: EXEC
    chk("c3_we", {31'd0, bus.rf_we}, 32'd1);
    chk("c3_opcode", {29'd0, bus.alu_opcode}, 32'd2);
    @(negedge clk);  // c4: FETCH of next instruction
    chk("c4_we", {31'd0, bus.rf_we}, 32'd0);
    chk("c4_addr", {24'd0, bus.imem_addr}, 32'd1);
    chk("c4_retired", {16'd0, bus.retired}, 32'd1);
    wait_halt(30);
    chk("halt_retired", {16'd0, bus.retired}, 32'd2);

    // HALT is sticky: no fetches while run toggles
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.run = i[0];
      if (bus.imem_req || !bus.halted || bus.rf_we || bus.alu_opcode != 3'd0) bad++;
    end
    chk("halt_quiet", bad, 0);
    chk("halt_retired_hold", {16'd0, bus.retired}, 32'd2);

    // Reset mid-fetch: one NOP retires, then the fetch of addr 1 never acks
    bus.run = 1'b0;
    rst     = 1'b1;
    imem[0] = 8'h00;
    dly[1]  = 200;
    @(negedge clk);
    rst = 1'b0;
    fq.push_back('{addr: 8'h00, ret: 16'd0});
    bus.run = 1'b1;
    @(negedge clk);
    bus.run = 1'b0;
    n = 0;
    while (!(bus.imem_req && bus.imem_addr == 8'h01) && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("midfetch_req", {31'd0, bus.imem_req}, 32'd1);
    chk("midfetch_retired", {16'd0, bus.retired}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_drop_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_clr_retired", {16'd0, bus.retired}, 32'd0);
    chk("rst_clr_pc", {24'd0, bus.imem_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Branching program: ack wait, JZ taken / not taken, pc wrap, HALT
    dly[0]     = 4;
    dly[1]     = 0;
    imem[0]    = 8'hAC;                         // MOV ra=1 rb=2
    imem[1]    = 8'h24; zf[1]    = 1'b1; tgt[1]    = 8'h10;  // JZ taken
    imem[8'h10] = 8'h9A;                        // XOR ra=3 rb=1
    imem[8'h11] = 8'h24; zf[8'h11] = 1'b0; tgt[8'h11] = 8'h40; // JZ not taken
    imem[8'h12] = 8'h76;                        // AND ra=2 rb=3
    imem[8'h13] = 8'h24; zf[8'h13] = 1'b1; tgt[8'h13] = 8'hFF; // JZ to last address
    imem[8'hFF] = 8'hC0;                        // NOP (opcode 110), pc wraps
    fq.push_back('{addr: 8'h00, ret: 16'd0});
    fq.push_back('{addr: 8'h01, ret: 16'd1});
    fq.push_back('{addr: 8'h10, ret: 16'd2});
    fq.push_back('{addr: 8'h11, ret: 16'd3});
    fq.push_back('{addr: 8'h12, ret: 16'd4});
    fq.push_back('{addr: 8'h13, ret: 16'd5});
    fq.push_back('{addr: 8'hFF, ret: 16'd6});
    fq.push_back('{addr: 8'h00, ret: 16'd7});
    wq.push_back({2'd1, 2'd2, 3'd5});
    wq.push_back({2'd3, 2'd1, 3'd4});
    wq.push_back({2'd2, 2'd3, 3'd3});
    @(negedge clk);
    chk("after_rst_idle", {31'd0, bus.imem_req}, 32'd0);
    bus.run = 1'b1;
    n_req = 0;
    bad   = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bus.run = 1'b0;
      if (bus.imem_req) begin
        n_req++;
        if (bus.imem_addr != 8'h00 || bus.alu_opcode != 3'd0) bad++;
        if (bus.imem_ack) break;
      end
    end
    chk("ack_wait_req_cycles", n_req, 5);
    chk("ack_wait_stable", bad, 0);
    // Second visit to address 0 (after the wrap) finds HALT
    imem[0] = 8'hE0;
    dly[0]  = 0;
    @(negedge clk);
    chk("mov_decode_op", {29'd0, bus.alu_opcode}, 32'd5);
    wait_halt(100);
    chk("prog_retired", {16'd0, bus.retired}, 32'd8);
    chk("fetch_queue_empty", fq.size(), 0);
    chk("wb_queue_empty", wq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
